// File: rtl/mult_rr_sched.sv
// Shared sequential signed multiplier with a two-port round-robin scheduler.
// Operands are converted to magnitudes, multiplied by shift-add over WIDTH cycles, then re-signed.
module mult_rr_sched #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req0,
  input  logic [WIDTH-1:0]   a0,
  input  logic [WIDTH-1:0]   b0,
  input  logic               req1,
  input  logic [WIDTH-1:0]   a1,
  input  logic [WIDTH-1:0]   b1,
  output logic               gnt0,
  output logic               gnt1,
  output logic               busy,
  output logic               done,
  output logic               done_id,
  output logic [2*WIDTH-1:0] out
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MULT = 2'd1,
    FIX  = 2'd2
  } state_t;

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]      CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0]      CNT_ONE  = CW'(1);
  localparam logic [2*WIDTH-1:0] PROD_ONE = {{(2*WIDTH-1){1'b0}}, 1'b1};

  // Two's-complement magnitude; the most negative value maps cleanly to 2^(WIDTH-1) as unsigned.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x);
    if (x[WIDTH-1]) begin
      magnitude = ~x + {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      magnitude = x;
    end
  endfunction

  state_t             state_r, state_s;
  logic               last_grant_r, last_grant_s;
  logic               sign_r, sign_s;
  logic [WIDTH-1:0]   mcand_r, mcand_s;
  logic [WIDTH-1:0]   mplier_r, mplier_s;
  logic [2*WIDTH-1:0] acc_r, acc_s;
  logic [CW-1:0]      cnt_r, cnt_s;
  logic               gnt0_s, gnt1_s, busy_s, done_s, done_id_s;
  logic [2*WIDTH-1:0] out_s;
  logic               sel_s;
  logic [WIDTH-1:0]   a_sel_s, b_sel_s;

  // Port selection: a lone requester wins, a tie goes to the port not granted last.
  always_comb begin
    if (req0 && req1) begin
      sel_s = ~last_grant_r;
    end else if (req1) begin
      sel_s = 1'b1;
    end else begin
      sel_s = 1'b0;
    end
    a_sel_s = sel_s ? a1 : a0;
    b_sel_s = sel_s ? b1 : b0;
  end

  // Next-state and next-output logic for the IDLE/MULT/FIX sequencer.
  always_comb begin
    state_s      = state_r;
    last_grant_s = last_grant_r;
    sign_s       = sign_r;
    mcand_s      = mcand_r;
    mplier_s     = mplier_r;
    acc_s        = acc_r;
    cnt_s        = cnt_r;
    gnt0_s       = 1'b0;
    gnt1_s       = 1'b0;
    done_s       = 1'b0;
    busy_s       = busy;
    done_id_s    = done_id;
    out_s        = out;
    case (state_r)
      IDLE: begin
        if (req0 || req1) begin
          sign_s       = a_sel_s[WIDTH-1] ^ b_sel_s[WIDTH-1];
          mcand_s      = magnitude(a_sel_s);
          mplier_s     = magnitude(b_sel_s);
          acc_s        = {(2*WIDTH){1'b0}};
          cnt_s        = {CW{1'b0}};
          last_grant_s = sel_s;
          done_id_s    = sel_s;
          gnt0_s       = ~sel_s;
          gnt1_s       = sel_s;
          busy_s       = 1'b1;
          state_s      = MULT;
        end else begin
          state_s = IDLE;
        end
      end
      MULT: begin
        if (mplier_r[0]) begin
          acc_s = acc_r + ({{WIDTH{1'b0}}, mcand_r} << cnt_r);
        end else begin
          acc_s = acc_r;
        end
        mplier_s = mplier_r >> 1;
        cnt_s    = cnt_r + CNT_ONE;
        if (cnt_r == CNT_LAST) begin
          state_s = FIX;
        end else begin
          state_s = MULT;
        end
      end
      FIX: begin
        // ~0+1 wraps back to 0, so a zero product with a negative sign stays 0.
        out_s   = sign_r ? (~acc_r + PROD_ONE) : acc_r;
        done_s  = 1'b1;
        busy_s  = 1'b0;
        state_s = IDLE;
      end
      default: begin
        busy_s  = 1'b0;
        state_s = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset; reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      last_grant_r <= 1'b1;
      sign_r       <= 1'b0;
      mcand_r      <= {WIDTH{1'b0}};
      mplier_r     <= {WIDTH{1'b0}};
      acc_r        <= {(2*WIDTH){1'b0}};
      cnt_r        <= {CW{1'b0}};
      gnt0         <= 1'b0;
      gnt1         <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      done_id      <= 1'b0;
      out          <= {(2*WIDTH){1'b0}};
    end else begin
      state_r      <= state_s;
      last_grant_r <= last_grant_s;
      sign_r       <= sign_s;
      mcand_r      <= mcand_s;
      mplier_r     <= mplier_s;
      acc_r        <= acc_s;
      cnt_r        <= cnt_s;
      gnt0         <= gnt0_s;
      gnt1         <= gnt1_s;
      busy         <= busy_s;
      done         <= done_s;
      done_id      <= done_id_s;
      out          <= out_s;
    end
  end

endmodule

// File: tb/tb_mult_rr_sched.sv
// Scoreboard bench for mult_rr_sched: directed requests push hand-computed products per port,
// a negedge monitor pops and compares on every done pulse.
module tb_mult_rr_sched;
  localparam int WIDTH = 4;

  logic               clk = 1'b0;
  logic               rst;
  logic               req0, req1;
  logic [WIDTH-1:0]   a0, b0, a1, b1;
  logic               gnt0, gnt1, busy, done, done_id;
  logic [2*WIDTH-1:0] out;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] exp_q0[$];
  logic [7:0] exp_q1[$];
  logic       gnt_log[$];
  bit         track_busy = 1'b0;
  int         bad_busy   = 0;

  mult_rr_sched #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .a0(a0), .b0(b0),
    .req1(req1), .a1(a1), .b1(b1),
    .gnt0(gnt0), .gnt1(gnt1), .busy(busy), .done(done),
    .done_id(done_id), .out(out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: scoreboard pop on done, grant exclusivity, grant logging.
  always @(negedge clk) begin
    if (!rst) begin
      if (gnt0 || gnt1) begin
        check("gnt_exclusive", {15'd0, gnt0 & gnt1}, 16'd0);
        gnt_log.push_back(gnt1);
      end
      if (track_busy && !busy && !done) bad_busy++;
      if (done) begin
        check("done_vs_gnt", {14'd0, gnt1, gnt0}, 16'd0);
        check("busy_in_done", {15'd0, busy}, 16'd0);
        if (done_id == 1'b0) begin
          if (exp_q0.size() == 0) check("unexpected_done0", {8'd0, out}, 16'hFFFF);
          else check("out_port0", {8'd0, out}, {8'd0, exp_q0.pop_front()});
        end else begin
          if (exp_q1.size() == 0) check("unexpected_done1", {8'd0, out}, 16'hFFFF);
          else check("out_port1", {8'd0, out}, {8'd0, exp_q1.pop_front()});
        end
      end
    end
  end

  task automatic wait_gnt(input logic port, output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (((port ? gnt1 : gnt0) !== 1'b1) && cyc < 30);
    if ((port ? gnt1 : gnt0) !== 1'b1) begin
      n_checks++;
      n_fail++;
      $display("FAIL gnt_timeout: port %0d got no grant in %0d cycles, required within 30", port, cyc);
    end
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (done !== 1'b1 && cyc < 30);
    if (done !== 1'b1) begin
      n_checks++;
      n_fail++;
      $display("FAIL done_timeout: no done in %0d cycles, required within 30", cyc);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Single request on one port, operands dropped after grant; expected product pushed first.
  task automatic run_one(input logic port, input logic [3:0] a, input logic [3:0] b,
                         input logic [7:0] exp);
    int c;
    if (port) begin
      exp_q1.push_back(exp);
      req1 = 1'b1; a1 = a; b1 = b;
    end else begin
      exp_q0.push_back(exp);
      req0 = 1'b1; a0 = a; b0 = b;
    end
    wait_gnt(port, c);
    if (port) req1 = 1'b0; else req0 = 1'b0;
    wait_done(c);
    check("latency_gnt_to_done", c[15:0], 16'(WIDTH + 1));
  endtask

  initial begin
    int c;
    int dones;
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
    a0 = 4'h0; b0 = 4'h0; a1 = 4'h0; b1 = 4'h0;
    repeat (2) @(negedge clk);
    check("reset_outputs", {4'd0, gnt0, gnt1, busy, done, out}, 16'd0);
    check("reset_done_id", {15'd0, done_id}, 16'd0);
    rst = 1'b0;

    // 5 * 2 = 10, grant one cycle after request, busy with grant
    exp_q0.push_back(8'd10);
    req0 = 1'b1; a0 = 4'd5; b0 = 4'd2;
    wait_gnt(1'b0, c);
    check("first_gnt_latency", c[15:0], 16'd1);
    check("busy_at_gnt", {15'd0, busy}, 16'd1);
    req0 = 1'b0;
    wait_done(c);
    check("latency_gnt_to_done", c[15:0], 16'(WIDTH + 1));
    repeat (3) @(negedge clk);
    check("idle_out_hold", {7'd0, busy, out}, 16'h000A);

    // Tie from reset: port 0 first (-3*4=-12), then port 1 (-8*-8=64)
    do_reset();
    gnt_log.delete();
    exp_q0.push_back(8'hF4);
    exp_q1.push_back(8'h40);
    req0 = 1'b1; a0 = 4'hD; b0 = 4'h4;
    req1 = 1'b1; a1 = 4'h8; b1 = 4'h8;
    wait_gnt(1'b0, c);
    req0 = 1'b0;
    wait_gnt(1'b1, c);
    check("tie_second_gnt_spacing", c[15:0], 16'(WIDTH + 2));
    req1 = 1'b0;
    wait_done(c);
    check("tie_grant_count", 16'(gnt_log.size()), 16'd2);
    if (gnt_log.size() == 2) check("tie_grant_order", {14'd0, gnt_log[0], gnt_log[1]}, 16'b01);

    // Port 1 alone: -8*7, 7*-1, 0*-5
    run_one(1'b1, 4'h8, 4'h7, 8'hC8);
    run_one(1'b1, 4'h7, 4'hF, 8'hF9);
    run_one(1'b1, 4'h0, 4'hB, 8'h00);
    run_one(1'b0, 4'h8, 4'h8, 8'h40);

    // Reset two edges into an operation: nothing completes
    req0 = 1'b1; a0 = 4'd3; b0 = 4'd5;
    wait_gnt(1'b0, c);
    req0 = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midop_reset_outputs", {4'd0, gnt0, gnt1, busy, done, out}, 16'd0);
    check("midop_reset_done_id", {15'd0, done_id}, 16'd0);
    rst = 1'b0;
    dones = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done) dones++;
    end
    check("midop_no_done", 16'(dones), 16'd0);

    // Tie after reset again favours port 0: 2*3=6, -1*-1=1
    gnt_log.delete();
    exp_q0.push_back(8'd6);
    exp_q1.push_back(8'd1);
    req0 = 1'b1; a0 = 4'd2; b0 = 4'd3;
    req1 = 1'b1; a1 = 4'hF; b1 = 4'hF;
    wait_gnt(1'b0, c);
    req0 = 1'b0;
    wait_gnt(1'b1, c);
    req1 = 1'b0;
    wait_done(c);
    if (gnt_log.size() == 2) check("rearb_grant_order", {14'd0, gnt_log[0], gnt_log[1]}, 16'b01);
    else check("rearb_grant_count", 16'(gnt_log.size()), 16'd2);

    // Port 1 held continuously: 3*3=9 three times, grants WIDTH+2 apart
    repeat (2) @(negedge clk);
    bad_busy = 0;
    req1 = 1'b1; a1 = 4'd3; b1 = 4'd3;
    for (int i = 0; i < 3; i++) begin
      exp_q1.push_back(8'd9);
      wait_gnt(1'b1, c);
      if (i == 0) track_busy = 1'b1;
      else check("held_gnt_spacing", c[15:0], 16'(WIDTH + 2));
      if (i == 2) req1 = 1'b0;
    end
    wait_done(c);
    track_busy = 1'b0;
    check("held_busy_low_only_in_done", 16'(bad_busy), 16'd0);

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 16'(exp_q0.size() + exp_q1.size()), 16'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
